// File: rtl/gol_pkg.sv
// Shared game-of-life board constants and streamer FSM encoding.
// Imported by the streamer, the update engine and the loader.
package gol_pkg;

    localparam int GOL_WIDTH  = 32;
    localparam int GOL_HEIGHT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    function automatic int row_aw(input int h);
        return (h > 2) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/gol_frame_streamer_if.sv
// Byte stream with valid/ready handshake and row/frame markers.
// The master drives data and markers, the slave drives ready.
interface gol_frame_streamer_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eol;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eol,
        output out_ready
    );

endinterface

// File: rtl/gol_row_serializer.sv
// Holds one board row and presents it one byte at a time,
// least-significant byte first.
module gol_row_serializer
    import gol_pkg::*;
#(
    parameter int WIDTH = GOL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             advance,
    output logic [7:0]       byte_out,
    output logic             first,
    output logic             last
);

    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;

    // Latch a new row or step to the next byte of the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= load_data;
            idx   <= '0;
        end else if (advance && !last) begin
            idx <= idx + 1'b1;
        end
    end

    assign byte_out = shreg[idx*8 +: 8];
    assign first    = (idx == '0);
    assign last     = (idx == IW'(NB - 1));

endmodule

// File: rtl/gol_frame_streamer.sv
// Reads the board row by row and streams every cell out as bytes
// so a host can dump each generation over the output pins.
module gol_frame_streamer
    import gol_pkg::*;
#(
    parameter int WIDTH  = GOL_WIDTH,
    parameter int HEIGHT = GOL_HEIGHT,
    parameter int ROW_AW = row_aw(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ROW_AW-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    gol_frame_streamer_if.master os,
    output logic [7:0]        frame_cnt
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(HEIGHT - 1);

    logic [1:0] state;
    logic       valid_q;
    logic       hs;
    logic       load;
    logic       ser_first;
    logic       ser_last;
    logic [7:0] ser_byte;

    assign hs   = valid_q & os.out_ready;
    // rd_en high marks the first READ cycle; RAM data lands in the second.
    assign load = (state == ST_READ) && !rd_en;

    gol_row_serializer #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (rd_data),
        .advance   (hs),
        .byte_out  (ser_byte),
        .first     (ser_first),
        .last      (ser_last)
    );

    assign os.out_valid = valid_q;
    assign os.out_data  = ser_byte;
    assign os.out_sof   = valid_q && (rd_addr == '0) && ser_first;
    assign os.out_eol   = valid_q && ser_last;

    // Frame sequencing: issue row reads, present bytes, count frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            valid_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rd_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!rd_en) begin
                        valid_q <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs && ser_last) begin
                        valid_q <= 1'b0;
                        if (rd_addr == LAST_ROW) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            rd_en   <= 1'b1;
                            state   <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Bench for gol_frame_streamer: a board RAM model, a byte monitor
// and a frame-level reference built from the stored rows.
module tb_gol_frame_streamer;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int NB = W / 8;
    localparam int AW = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [7:0]    frame_cnt;

    gol_frame_streamer_if sif();

    gol_frame_streamer #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .os        (sif),
        .frame_cnt (frame_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0;
    int    ready_mode = 0;
    logic [W-1:0] mem [H];
    beat_t rcv [$];
    beat_t exp_q [$];
    beat_t held;
    logic  stalled = 1'b0;

    always #5 clk = ~clk;

    // Board RAM: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Host ready pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: sif.out_ready = 1'b1;
            1: sif.out_ready = ~sif.out_ready;
            2: sif.out_ready = 1'($urandom_range(0, 1));
            default: sif.out_ready = 1'b0;
        endcase
    end

    // Byte monitor: records handshakes and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                checks++;
                if (sif.out_valid !== 1'b1 ||
                    {sif.out_data, sif.out_sof, sif.out_eol} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b %h req v=1 %h",
                             sif.out_valid,
                             {sif.out_data, sif.out_sof, sif.out_eol}, held);
                end
            end
            if (sif.out_valid && sif.out_ready)
                rcv.push_back({sif.out_data, sif.out_sof, sif.out_eol});
            stalled = sif.out_valid && !sif.out_ready;
            held    = {sif.out_data, sif.out_sof, sif.out_eol};
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < H; i++) mem[i] = W'($urandom);
    endtask

    // Reference: every row split into bytes, low byte first.
    task automatic make_expected();
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back({mem[r][b*8 +: 8],
                                 1'(r == 0 && b == 0),
                                 1'(b == NB - 1)});
    endtask

    task automatic run_frame();
        bit done = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (!busy) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL frame_timeout busy=%b req 0", busy);
        end
        exp_frames++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, rd_en, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b req 0", {busy, rd_en, rd_addr});
        end
        checks++;
        if ({sif.out_valid, sif.out_sof, sif.out_eol, sif.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_out got %h req 0",
                     {sif.out_valid, sif.out_sof, sif.out_eol, sif.out_data});
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d req 0", frame_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        exp_frames = 0;
    endtask

    task automatic test_directed();
        logic [7:0] bytes [8];
        bytes = '{8'h01, 8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80};
        mem[0] = 16'hA501; mem[1] = 16'h0000;
        mem[2] = 16'hFFFF; mem[3] = 16'h8001;
        ready_mode = 0;
        rcv.delete();
        run_frame();
        checks++;
        if (rcv.size() !== 8) begin
            errors++;
            $display("FAIL dir_len got %0d req 8", rcv.size());
        end
        for (int i = 0; i < 8 && i < rcv.size(); i++) begin
            checks++;
            if (rcv[i] !== {bytes[i], 1'(i == 0), 1'(i % 2 == 1)}) begin
                errors++;
                $display("FAIL dir_byte%0d got %h req %h", i, rcv[i],
                         {bytes[i], 1'(i == 0), 1'(i % 2 == 1)});
            end
        end
        checks++;
        if (frame_cnt !== 8'(exp_frames) || busy !== 1'b0) begin
            errors++;
            $display("FAIL dir_end got cnt=%0d busy=%b req cnt=%0d busy=0",
                     frame_cnt, busy, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            fill_random();
            make_expected();
            ready_mode = m;
            rcv.delete();
            run_frame();
            checks++;
            if (rcv.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL bp_len mode%0d got %0d req %0d", m,
                         rcv.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rcv.size(); i++) begin
                checks++;
                if (rcv[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_byte%0d mode%0d got %h req %h",
                             i, m, rcv[i], exp_q[i]);
                end
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_latency();
        bit done = 0;
        fill_random();
        ready_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if ({rd_en, rd_addr, busy, sif.out_valid} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lat_c0 got %b req 10010",
                     {rd_en, rd_addr, busy, sif.out_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({rd_en, sif.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL lat_c1 got %b req 00", {rd_en, sif.out_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({sif.out_valid, sif.out_sof, sif.out_data} !== {2'b11, mem[0][7:0]}) begin
            errors++;
            $display("FAIL lat_c2 got %h req %h",
                     {sif.out_valid, sif.out_sof, sif.out_data},
                     {2'b11, mem[0][7:0]});
        end
        @(posedge clk); #1;
        checks++;
        if ({sif.out_valid, sif.out_eol, sif.out_data} !== {2'b11, mem[0][15:8]}) begin
            errors++;
            $display("FAIL lat_c3 got %h req %h",
                     {sif.out_valid, sif.out_eol, sif.out_data},
                     {2'b11, mem[0][15:8]});
        end
        @(posedge clk); #1;
        checks++;
        if ({rd_en, rd_addr, sif.out_valid} !== {1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL lat_row1 got %b req 1010",
                     {rd_en, rd_addr, sif.out_valid});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({sif.out_valid, sif.out_data} !== {1'b1, mem[1][7:0]}) begin
            errors++;
            $display("FAIL lat_turn got %h req %h",
                     {sif.out_valid, sif.out_data}, {1'b1, mem[1][7:0]});
        end
        for (int c = 0; c < 200 && !done; c++) begin
            if (!busy) done = 1;
            else begin @(posedge clk); #1; end
        end
        exp_frames++;
        checks++;
        if (!done || frame_cnt !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL lat_end got cnt=%0d busy=%b req cnt=%0d busy=0",
                     frame_cnt, busy, exp_frames);
        end
    endtask

    task automatic test_ignored_start();
        fill_random();
        make_expected();
        ready_mode = 0;
        rcv.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 26; c++) begin
            #1 start = (c == 3 || c == 5 || c == 15);
            @(posedge clk);
        end
        #1 start = 1'b0;
        exp_frames++;
        checks++;
        if (rcv.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ign_len got %0d req %0d", rcv.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv.size(); i++) begin
            checks++;
            if (rcv[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ign_byte%0d got %h req %h", i, rcv[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL ign_end got cnt=%0d busy=%b req cnt=%0d busy=0",
                     frame_cnt, busy, exp_frames);
        end
    endtask

    task automatic test_reset_midframe();
        bit hit = 0;
        fill_random();
        ready_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rcv.delete();
        for (int c = 0; c < 200 && !hit; c++) begin
            if (rcv.size() >= 4) hit = 1;
            else begin @(posedge clk); #1; end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || {busy, rd_en, rd_addr, sif.out_valid, sif.out_sof,
                     sif.out_eol, sif.out_data, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b v=%b d=%h cnt=%0d req all 0",
                     busy, sif.out_valid, sif.out_data, frame_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        exp_frames = 0;
        make_expected();
        rcv.delete();
        run_frame();
        checks++;
        if (rcv.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rst_len got %0d req %0d", rcv.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv.size(); i++) begin
            checks++;
            if (rcv[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_byte%0d got %h req %h", i, rcv[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL rst_cnt got %0d req %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        int sofs;
        int bad = 0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_frames = 0;
        ready_mode = 2;
        for (int f = 0; f < 256; f++) begin
            fill_random();
            make_expected();
            rcv.delete();
            run_frame();
            sofs = 0;
            foreach (rcv[i]) if (rcv[i].sof) sofs++;
            checks++;
            if (sofs !== 1 || rcv.size() !== exp_q.size() || rcv != exp_q) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL b2b_frame%0d got sof=%0d len=%0d req sof=1 len=%0d",
                             f, sofs, rcv.size(), exp_q.size());
            end
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL b2b_255 got %0d req 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'(exp_frames % 256)) begin
            errors++;
            $display("FAIL b2b_wrap got %0d req %0d", frame_cnt, exp_frames % 256);
        end
        ready_mode = 0;
    endtask

    initial begin
        sif.out_ready = 1'b0;
        rd_data = '0;
        for (int i = 0; i < H; i++) mem[i] = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_latency();
        test_ignored_start();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gol_frame_streamer.md
Name: gol_frame_streamer

Overview:
- Reader/transmitter end of the game-of-life board interface: on request, reads the board RAM row by row and streams the cells out as bytes.
- Uses a valid/ready handshake so an external host can dump each generation through the TinyTapeout output pins.
- Sits beside the cell-update engine in the core, between the board memory read port and the uo_out / uio pin mapping in the top wrapper.

Parameters:
- WIDTH, 32, cells per row; multiple of 8, 8..64.
- HEIGHT, 32, rows per board; 2..64.
- ROW_AW, $clog2(HEIGHT), row address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to stream one full frame.
- busy  out  1  high from accepted start until the last byte handshakes.
- rd_en  out  1  board RAM read enable.
- rd_addr  out  ROW_AW  board row address.
- rd_data  in  WIDTH  row contents, valid exactly 1 cycle after rd_en; bit i = column i.
- out_data  out  8  streamed byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts the byte; already synchronized to clk.
- out_sof  out  1  qualifies byte 0 of row 0; valid only with out_valid.
- out_eol  out  1  qualifies the last byte of each row; valid only with out_valid.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously clears all state: busy=0, rd_en=0, rd_addr=0, out_valid=0, out_sof=0, out_eol=0, out_data=0, frame_cnt=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: start=1 -> row=0, assert rd_en with rd_addr=0, busy=1, go READ.
  - READ: one wait cycle; capture rd_data into the row shift register on the following edge, byte index=0, go SEND.
  - SEND: out_valid=1; out_data = shreg[8*idx+7 : 8*idx], least-significant byte first.
    - Handshake = out_valid & out_ready on a rising edge.
    - On handshake, not last byte: idx+1.
    - On handshake, last byte and row < HEIGHT-1: row+1, rd_en pulse, go READ.
    - On handshake, last byte and row = HEIGHT-1: frame_cnt+1, busy=0, go IDLE.
- Handshake rules:
  - out_data, out_sof and out_eol stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- rd_en is a single-cycle pulse per row; rd_addr holds until the next row is issued.
- Latency:
  - start -> first out_valid: 2 cycles (rd_en in cycle 0, data captured at edge 1, out_valid high in cycle 2).
  - Row turnaround with out_ready held high: 2 idle cycles between a row's last byte and the next row's first byte.
  - Frame length: HEIGHT*WIDTH/8 handshakes.
- Boundary conditions:
  - start while busy is ignored; it does not restart or queue.
  - start in the same cycle the final handshake returns the FSM to IDLE is ignored; the FSM must be in IDLE when start is sampled.
  - out_ready high while out_valid is low has no effect.
  - Reset mid-frame aborts immediately; frame_cnt is not incremented; the next start begins at row 0.
  - Board contents changing mid-frame are not this block's concern. Rows already latched are unaffected.

Decomposition:
- Shared package gol_pkg holds: board WIDTH/HEIGHT defaults, ROW_AW function, and the FSM state enum (IDLE, READ, SEND).
- The same constants are reused by the update engine and the loader.
- One natural sub-module, gol_row_serializer:
  - WIDTH-bit load, byte-indexed output, last-byte flag.
  - Driven by load and advance strobes.
- The FSM stays in gol_frame_streamer.

Test Plan:
- WIDTH=16, HEIGHT=4, rows 0..3 = 16'hA501, 16'h0000, 16'hFFFF, 16'h8001; start with out_ready=1 -> bytes 01,A5,00,00,FF,FF,01,80; out_sof only on byte 0; out_eol on bytes 1,3,5,7; frame_cnt=1; busy low after the last handshake.
- Backpressure: out_ready toggling 1/0 on every cycle (alternating) -> same 8-byte sequence; out_data stable while stalled; no byte dropped or duplicated.
- Latency: start at cycle 0, out_ready=1 -> rd_en at cycle 0, out_valid first high at cycle 2; rd_addr=1 pulse appears 1 cycle after the handshake of byte 1.
- start pulsed in cycles 3 and 5 mid-frame -> ignored; exactly 8 bytes; frame_cnt increments by 1 only.
- rst_n low after byte 4 -> all outputs at reset values asynchronously; frame_cnt=0; a new start streams again from byte 01.
- 256 back-to-back frames -> frame_cnt wraps to 0; out_sof appears exactly once per frame.
